// File: rtl/uart_pkg.sv
// Shared UART definitions: default character width and the echo responder states.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        GAP,
        SEND,
        WAIT_DONE
    } echo_state_t;

endpackage : uart_pkg

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read. A push is still accepted
// when full provided a pop happens on the same edge.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = UART_DATA_BITS,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     nrst_in,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    // When full, the slot being written is the one being popped, so both can proceed.
    assign w_push_ok = push && (!full || pop);
    assign w_pop_ok  = pop && !empty;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head_data = r_mem[r_rd_ptr];

    // Storage write.
    // NOTE: the data array has no reset; occupancy is tracked by the pointers and count, so stale contents are never read.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH (a power of two); count tracks occupancy.
    // NOTE: non-blocking assignments keep every register sampling pre-edge values, avoiding simulation races.
    always_ff @(posedge clk or negedge nrst_in) begin
        if (!nrst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : sync_fifo

// File: rtl/uart_echo.sv
// Echo responder: buffers received characters and offers each one back to the
// transmitter after an idle gap, holding the request until the stop bit ends.
module uart_echo
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int FIFO_DEPTH = 16,
    parameter int GAP_CYCLES = 100
) (
    input  logic                          clk,
    input  logic                          nrst_in,
    input  logic [DATA_BITS-1:0]          rx_data_in,
    input  logic                          rx_data_rdy_in,
    output logic [DATA_BITS-1:0]          tx_data_out,
    output logic                          tx_data_rdy_out,
    input  logic                          tx_done_in,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out,
    output logic                          overflow_out
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    // With no gap the machine goes straight to SEND wherever it would enter GAP.
    localparam echo_state_t PRE_SEND = (GAP_CYCLES == 0) ? SEND : GAP;

    logic                        r_rx_rdy_d;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_more;
    logic [DATA_BITS-1:0]        w_head;
    logic [$clog2(FIFO_DEPTH):0] w_count;
    logic                        w_full;
    logic                        w_empty;
    echo_state_t                 r_state;
    echo_state_t                 w_state_next;
    logic [GW-1:0]               r_gap_cnt;
    logic [DATA_BITS-1:0]        r_tx_data;
    logic                        r_tx_rdy;
    logic                        r_overflow;

    assign w_push = rx_data_rdy_in && !r_rx_rdy_d;
    assign w_pop  = (r_state == WAIT_DONE) && tx_done_in;
    // Occupancy after this edge's pop, counting a push landing on the same edge.
    assign w_more = (w_count > 1) || w_push;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .nrst_in   (nrst_in),
        .push      (w_push),
        .push_data (rx_data_in),
        .pop       (w_pop),
        .head_data (w_head),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    // Registered copy of the receive-valid line for rising-edge detection.
    always_ff @(posedge clk or negedge nrst_in) begin
        if (!nrst_in) r_rx_rdy_d <= 1'b0;
        else          r_rx_rdy_d <= rx_data_rdy_in;
    end

    // Echo state register.
    always_ff @(posedge clk or negedge nrst_in) begin
        if (!nrst_in) r_state <= IDLE;
        else          r_state <= w_state_next;
    end

    // Next-state decode.
    // NOTE: the default assignment first means every path assigns w_state_next, so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:      if (!w_empty) w_state_next = PRE_SEND;
            GAP:       if (r_gap_cnt == GAP_LAST) w_state_next = SEND;
            SEND:      w_state_next = WAIT_DONE;
            WAIT_DONE: if (tx_done_in) w_state_next = w_more ? PRE_SEND : IDLE;
            default:   w_state_next = IDLE;
        endcase
    end

    // Gap counter runs only while staying in GAP, and is zero on every entry.
    always_ff @(posedge clk or negedge nrst_in) begin
        if (!nrst_in)                                     r_gap_cnt <= '0;
        else if (r_state == GAP && w_state_next == GAP)   r_gap_cnt <= r_gap_cnt + 1'b1;
        else                                              r_gap_cnt <= '0;
    end

    // Transmit request: load the head in SEND, hold it until the stop bit completes.
    always_ff @(posedge clk or negedge nrst_in) begin
        if (!nrst_in) begin
            r_tx_data <= '0;
            r_tx_rdy  <= 1'b0;
        end else if (r_state == SEND) begin
            r_tx_data <= w_head;
            r_tx_rdy  <= 1'b1;
        end else if (w_pop) begin
            r_tx_rdy  <= 1'b0;
        end
    end

    // Sticky drop flag: a push into a full FIFO with no pop to make room.
    always_ff @(posedge clk or negedge nrst_in) begin
        if (!nrst_in)                          r_overflow <= 1'b0;
        else if (w_push && w_full && !w_pop)   r_overflow <= 1'b1;
    end

    assign tx_data_out     = r_tx_data;
    assign tx_data_rdy_out = r_tx_rdy;
    assign fifo_count_out  = w_count;
    assign overflow_out    = r_overflow;

endmodule : uart_echo

// File: tb/tb_uart_echo.sv
// Bench for uart_echo: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a queue-based model.
module tb_uart_echo;

    localparam int DEPTH = 4;
    localparam int GAP   = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          nrst_in;
    logic [7:0]    rx_data_in;
    logic          rx_data_rdy_in;
    logic [7:0]    tx_data_out;
    logic          tx_data_rdy_out;
    logic          tx_done_in;
    logic [CW-1:0] fifo_count_out;
    logic          overflow_out;

    int n_vec = 0;
    int n_err = 0;

    uart_echo #(
        .DATA_BITS  (8),
        .FIFO_DEPTH (DEPTH),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk             (clk),
        .nrst_in         (nrst_in),
        .rx_data_in      (rx_data_in),
        .rx_data_rdy_in  (rx_data_rdy_in),
        .tx_data_out     (tx_data_out),
        .tx_data_rdy_out (tx_data_rdy_out),
        .tx_done_in      (tx_done_in),
        .fifo_count_out  (fifo_count_out),
        .overflow_out    (overflow_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Queue of buffered characters; the request line is modelled by its timing
    // rules: rises GAP+2 edges after a push into an idle, empty buffer, or
    // GAP+1 edges after a completed character when more remain.
    logic [7:0] q[$];
    bit         m_ovf, m_rdy, m_pend, m_prev;
    longint     m_edge = 0;
    longint     m_deadline;

    always @(posedge clk or negedge nrst_in) begin
        bit pop, push;
        if (!nrst_in) begin
            q.delete();
            m_ovf = 0; m_rdy = 0; m_pend = 0; m_prev = 0;
        end else begin
            m_edge++;
            pop  = m_rdy && tx_done_in;
            push = rx_data_rdy_in && !m_prev;
            m_prev = rx_data_rdy_in;
            if (pop) begin
                void'(q.pop_front());
                m_rdy = 0;
            end
            if (push) begin
                if (q.size() < DEPTH) q.push_back(rx_data_in);
                else                  m_ovf = 1;
            end
            if (pop && q.size() != 0) begin
                m_pend = 1; m_deadline = m_edge + GAP + 1;
            end else if (push && !m_rdy && !m_pend && q.size() == 1) begin
                m_pend = 1; m_deadline = m_edge + GAP + 2;
            end
            if (m_pend && m_edge == m_deadline) begin
                m_rdy = 1; m_pend = 0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (nrst_in) begin
            check("cycle_count", 32'(fifo_count_out), 32'(q.size()));
            check("cycle_overflow", 32'(overflow_out), 32'(m_ovf));
            check("cycle_rdy", 32'(tx_data_rdy_out), 32'(m_rdy));
            if (m_rdy && q.size() != 0) check("cycle_data", 32'(tx_data_out), 32'(q[0]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        #1;
        nrst_in = 1'b0;
        #1;
        check("rst_tx_data", 32'(tx_data_out), 32'h0);
        check("rst_tx_rdy", 32'(tx_data_rdy_out), 32'h0);
        check("rst_count", 32'(fifo_count_out), 32'h0);
        check("rst_overflow", 32'(overflow_out), 32'h0);
        rx_data_rdy_in = 1'b0;
        tx_done_in     = 1'b0;
        repeat (2) tick();
        nrst_in = 1'b1;
        tick();
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_data_in     = b;
        rx_data_rdy_in = 1'b1;
        tick();
        rx_data_rdy_in = 1'b0;
        tick();
    endtask

    task automatic wait_rdy(input string name);
        int k = 0;
        while (!tx_data_rdy_out && k < 200) begin
            tick();
            k++;
        end
        check({name, "_wait_rdy"}, 32'(tx_data_rdy_out), 32'h1);
    endtask

    // Waits for a request, checks the character, then completes it.
    task automatic serve_one(input string name, input logic [7:0] exp_b, output int waited);
        waited = 0;
        while (!tx_data_rdy_out && waited < 200) begin
            tick();
            waited++;
        end
        check({name, "_rdy"}, 32'(tx_data_rdy_out), 32'h1);
        check({name, "_data"}, 32'(tx_data_out), 32'(exp_b));
        repeat ($urandom_range(0, 3)) tick();
        tx_done_in = 1'b1;
        tick();
        tx_done_in = 1'b0;
        check({name, "_fall"}, 32'(tx_data_rdy_out), 32'h0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [7:0] exp_ovf [4]  = '{8'h10, 8'h11, 8'h12, 8'h13};
        logic [7:0] exp_full [4] = '{8'h21, 8'h22, 8'h23, 8'h55};

        nrst_in        = 1'b1;
        rx_data_in     = '0;
        rx_data_rdy_in = 1'b0;
        tx_done_in     = 1'b0;

        // Single byte: request after 1 + GAP + 1 cycles.
        do_reset();
        rx_data_in = 8'hA5; rx_data_rdy_in = 1'b1;
        tick();
        rx_data_rdy_in = 1'b0;
        serve_one("single", 8'hA5, w);
        check("single_latency", 32'(w), 32'd6);
        check("single_count_after", 32'(fifo_count_out), 32'd0);

        // Burst ordering while the first is awaiting completion.
        push_byte(8'h01);
        wait_rdy("burst");
        rx_data_in = 8'h02; rx_data_rdy_in = 1'b1;
        tick();
        rx_data_rdy_in = 1'b0;
        repeat (2) tick();
        rx_data_in = 8'h03; rx_data_rdy_in = 1'b1;
        tick();
        rx_data_rdy_in = 1'b0;
        serve_one("burst0", 8'h01, w);
        serve_one("burst1", 8'h02, w);
        check("burst1_gap", 32'(w >= GAP + 1), 32'h1);
        serve_one("burst2", 8'h03, w);
        check("burst2_gap", 32'(w >= GAP + 1), 32'h1);

        // Overflow: fifth byte dropped, flag sticky.
        do_reset();
        for (int i = 0; i < 5; i++) push_byte(8'h10 + 8'(i));
        check("ovf_count", 32'(fifo_count_out), 32'd4);
        check("ovf_flag", 32'(overflow_out), 32'h1);
        for (int i = 0; i < 4; i++) serve_one("ovf_out", exp_ovf[i], w);
        repeat (20) tick();
        check("ovf_no_extra", 32'(tx_data_rdy_out), 32'h0);
        check("ovf_drained", 32'(fifo_count_out), 32'd0);

        // Full FIFO with push and pop on the same edge.
        do_reset();
        for (int i = 0; i < 4; i++) push_byte(8'h20 + 8'(i));
        wait_rdy("full");
        rx_data_in = 8'h55; rx_data_rdy_in = 1'b1; tx_done_in = 1'b1;
        tick();
        rx_data_rdy_in = 1'b0; tx_done_in = 1'b0;
        check("full_pp_count", 32'(fifo_count_out), 32'd4);
        check("full_pp_ovf", 32'(overflow_out), 32'h0);
        for (int i = 0; i < 4; i++) serve_one("full_out", exp_full[i], w);

        // Level held high: exactly one push.
        rx_data_in = 8'h3C; rx_data_rdy_in = 1'b1;
        repeat (50) tick();
        rx_data_rdy_in = 1'b0;
        check("level_count", 32'(fifo_count_out), 32'd1);
        serve_one("level", 8'h3C, w);
        repeat (20) tick();
        check("level_no_repeat", 32'(tx_data_rdy_out), 32'h0);
        check("level_count_end", 32'(fifo_count_out), 32'd0);

        // Reset mid-transfer with two bytes queued.
        push_byte(8'h77);
        push_byte(8'h88);
        wait_rdy("midrst");
        do_reset();
        repeat (20) tick();
        check("midrst_rdy", 32'(tx_data_rdy_out), 32'h0);
        check("midrst_count", 32'(fifo_count_out), 32'd0);

        // Randomized traffic; the model checks every cycle.
        do_reset();
        fork
            begin
                repeat (1500) begin
                    rx_data_rdy_in = ($urandom_range(0, 3) == 0);
                    rx_data_in     = 8'($urandom);
                    tick();
                end
                rx_data_rdy_in = 1'b0;
            end
            begin
                repeat (1500) begin
                    tx_done_in = tx_data_rdy_out ? ($urandom_range(0, 3) == 0)
                                                 : ($urandom_range(0, 15) == 0);
                    tick();
                end
                tx_done_in = 1'b0;
            end
        join
        for (int k = 0; k < 400; k++) begin
            if (fifo_count_out == '0 && !tx_data_rdy_out) break;
            tx_done_in = tx_data_rdy_out;
            tick();
        end
        tx_done_in = 1'b0;
        tick();
        check("random_drained", 32'(fifo_count_out), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_uart_echo

// File: doc/uart_echo.md
Name: uart_echo

Overview:
- Responder end of the UART echo loop. It takes bytes presented by the uart receive side, buffers them in a FIFO, and hands each one back to the uart transmit side after a programmable idle gap.
- It sits between the `uart` instance's RX outputs and TX inputs, with both connections internal to the design.
- It turns the uart into a self-contained echo target, so a host or bench acting as initiator can check round-trip data.

Parameters:
- DATA_BITS, 8, width of one UART character.
- FIFO_DEPTH, 16, echo buffer entries; must be a power of 2 and at least 2.
- GAP_CYCLES, 100, clk cycles waited before each character is offered to TX; 0 means no gap.

Ports:
- clk  in  1  system clock.
- nrst_in  in  1  reset, asynchronous, active-low.
- rx_data_in  in  DATA_BITS  received character, from the uart `rx_data_out`.
- rx_data_rdy_in  in  1  receive-valid, from the uart `data_rdy_out`; pulse or level, only its rising edge is used.
- tx_data_out  out  DATA_BITS  character to send, to the uart `tx_data_in`.
- tx_data_rdy_out  out  1  send request, to the uart `data_rdy_in`.
- tx_done_in  in  1  one-cycle pulse from the uart `tx_done_out` at the end of the stop bit.
- fifo_count_out  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow_out  out  1  sticky flag: a received byte was dropped.

Behaviour:
- Reset values, applied immediately and asynchronously on nrst_in low:
  - tx_data_out = 0, tx_data_rdy_out = 0, fifo_count_out = 0, overflow_out = 0.
  - State is IDLE, FIFO pointers are 0, gap counter is 0, edge-detect register is 0.
  - Reset mid-transfer abandons the current character and all buffered data.
- RX capture:
  - The block registers rx_data_rdy_in.
  - A push occurs on the clk edge where rx_data_rdy_in = 1 and the previous registered value = 0; rx_data_in is written that same edge.
  - A level held high for many cycles gives exactly one push.
  - fifo_count_out reflects the push on the following cycle.
- Full FIFO:
  - A push with count = FIFO_DEPTH and no pop in the same cycle drops the byte. The FIFO is unchanged and overflow_out is set to 1 until reset.
  - A push and a pop in the same cycle when full: both take effect, count stays FIFO_DEPTH, overflow_out is not set.
- Pointers: log2(FIFO_DEPTH) bits, wrapping naturally; the count is tracked separately.
- State machine:
  - IDLE: tx_data_rdy_out = 0. When count > 0, go to GAP, or to SEND if GAP_CYCLES = 0. The gap counter loads 0.
  - GAP: the counter increments each cycle. When it reaches GAP_CYCLES-1, go to SEND.
  - SEND (one cycle): register tx_data_out <= FIFO head and tx_data_rdy_out <= 1, then go to WAIT_DONE.
  - WAIT_DONE: hold tx_data_out stable with tx_data_rdy_out = 1. On tx_done_in = 1:
    - pop the head;
    - register tx_data_rdy_out <= 0;
    - go to GAP if the post-pop count > 0 (SEND if GAP_CYCLES = 0), otherwise go to IDLE.
- tx_data_rdy_out is therefore low for at least 1 cycle between characters. This guarantees the uart does not resend stale data.
- tx_done_in outside WAIT_DONE is ignored.
- Latency: the first echo request rises 1 + GAP_CYCLES + 1 cycles after the push edge. GAP_CYCLES = 0 gives 2 cycles.
- Order is strict FIFO; no byte is duplicated and none is reordered.
- Pushes continue normally during GAP, SEND and WAIT_DONE.

Decomposition:
- Package uart_pkg: DATA_BITS default constant and the echo state enum (IDLE, GAP, SEND, WAIT_DONE). Both are shared with future uart blocks.
- Sub-module sync_fifo, parameterised by WIDTH and DEPTH:
  - ports: push, push_data, pop, head_data, count, full, empty;
  - combinational head read;
  - same-cycle push+pop allowed when full.
- uart_echo keeps the edge detect, gap counter, FSM and overflow flag.

Test Plan:
- Single byte: reset, push 0xA5, GAP_CYCLES = 4 → tx_data_rdy_out rises 6 cycles after the push edge with tx_data_out = 0xA5. Pulse tx_done_in → tx_data_rdy_out falls next cycle and fifo_count_out = 0.
- Burst ordering: push 0x01, 0x02, 0x03 back-to-back, 3 cycles apart, while the first is in WAIT_DONE → outputs 0x01, 0x02, 0x03 in order. Each request is separated by at least GAP_CYCLES + 1 low cycles.
- Overflow: FIFO_DEPTH = 4, hold tx_done_in low, push 0x10..0x14 → count = 4 and overflow_out = 1. Released output is 0x10..0x13; 0x14 is never sent.
- Full push+pop: FIFO full, push 0x55 on the same cycle as tx_done_in → count stays 4, overflow_out = 0, and 0x55 is sent last.
- Level input: rx_data_rdy_in held high for 50 cycles with 0x3C → exactly one push and one echo of 0x3C.
- Reset mid-operation: nrst_in low during WAIT_DONE with 2 bytes queued → outputs clear without waiting for a clk edge. After release there is no echo request and count = 0.
- Loopback with the uart at 100 MHz / 115200 baud: host sends 16 random bytes → 16 identical bytes return in order.
